// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: states, opcodes,
// memory commands and strobe bit positions.
package cpu_ctrl_pkg;

    // Outputs decode from state alone, so instruction-dependent strobes get their own states.
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DEC, S_GETA, S_GETB, S_EXEC, S_EXEC_A,
        S_CMP, S_ADDR, S_LDA, S_MEM_RD, S_GETD, S_PASSD, S_MEM_WR,
        S_WR_REG, S_WR_IMM, S_WR_LDR, S_ILL, S_HALTED
    } state_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] NSEL_RN   = 2'b00;
    localparam logic [1:0] NSEL_RD   = 2'b01;
    localparam logic [1:0] NSEL_RM   = 2'b10;
    localparam logic [1:0] NSEL_NONE = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam int DP_LOADA   = 8;
    localparam int DP_LOADB   = 7;
    localparam int DP_LOADC   = 6;
    localparam int DP_LOADS   = 5;
    localparam int DP_ASEL    = 4;
    localparam int DP_BSEL    = 3;
    localparam int DP_VSEL_HI = 2;
    localparam int DP_VSEL_LO = 1;
    localparam int DP_WRITE   = 0;

    localparam int TOP_LOAD_PC  = 3;
    localparam int TOP_LOAD_IR  = 2;
    localparam int TOP_RESET_PC = 1;
    localparam int TOP_ADDR_SEL = 0;

endpackage

// File: rtl/fsm_control_p_mem_wait_cnt.sv
// Memory wait-state counter shared by instruction fetch and data read;
// done is raised in the last cycle of a MEM_RD_LAT-cycle read.
module mem_wait_cnt #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [3:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign done = (cnt_reg == 4'(MEM_RD_LAT - 1));

endmodule

// File: rtl/fsm_control_p.sv
// Parametrised multicycle instruction controller (Moore FSM).
// Define FSM_INSTR_CNT_EN to add the retired-instruction counter port instr_cnt.
module fsm_control_p
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_RD_LAT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [8:0] dp_ctrl,
    output logic [1:0] nsel,
    output logic [3:0] top_ctrl,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       w,
    output logic       halted,
    output logic       illegal
`ifdef FSM_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state_reg;
    logic   wait_done;

    wire is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    wire is_b_only  = ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
                      ((opcode == OPC_ALU) && (op == OP_MVN));
    wire is_mem     = (opcode == OPC_LDR) || (opcode == OPC_STR);

    mem_wait_cnt #(.MEM_RD_LAT(MEM_RD_LAT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_reg == S_IF1) || (state_reg == S_LDA)),
        .enable ((state_reg == S_IF2) || (state_reg == S_MEM_RD)),
        .done   (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_RST;
        end else begin
            case (state_reg)
                S_RST:    state_reg <= S_IF1;
                S_IF1:    state_reg <= S_IF2;
                S_IF2:    if (wait_done) state_reg <= S_UPD_PC;
                S_UPD_PC: state_reg <= S_DEC;
                S_DEC: begin
                    if (is_mov_imm)                           state_reg <= S_WR_IMM;
                    else if (is_b_only)                       state_reg <= S_GETB;
                    else if ((opcode == OPC_ALU) || is_mem)   state_reg <= S_GETA;
                    else if (opcode == OPC_HALT)              state_reg <= S_HALTED;
                    else                                      state_reg <= S_ILL;
                end
                S_GETA:   state_reg <= is_mem ? S_ADDR : S_GETB;
                S_GETB: begin
                    if ((opcode == OPC_ALU) && (op == OP_CMP)) state_reg <= S_CMP;
                    else if (is_b_only)                        state_reg <= S_EXEC_A;
                    else                                       state_reg <= S_EXEC;
                end
                S_EXEC, S_EXEC_A: state_reg <= S_WR_REG;
                S_ADDR:   state_reg <= S_LDA;
                S_LDA:    state_reg <= (opcode == OPC_LDR) ? S_MEM_RD : S_GETD;
                S_MEM_RD: if (wait_done) state_reg <= S_WR_LDR;
                S_GETD:   state_reg <= S_PASSD;
                S_PASSD:  state_reg <= S_MEM_WR;
                S_CMP, S_MEM_WR, S_WR_REG, S_WR_IMM, S_WR_LDR, S_ILL: state_reg <= S_IF1;
                S_HALTED: state_reg <= S_HALTED;
                default:  state_reg <= S_RST;
            endcase
        end
    end

`ifdef FSM_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt_reg;

    // Every state listed here leaves unconditionally for IF1, i.e. an instruction retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt_reg <= '0;
        end else if (state_reg inside {S_CMP, S_MEM_WR, S_WR_REG, S_WR_IMM, S_WR_LDR, S_ILL}) begin
            instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign instr_cnt = instr_cnt_reg;
`else
    if (CNT_W == 0) begin : g_no_cnt
    end
`endif

    always_comb begin
        dp_ctrl   = '0;
        nsel      = NSEL_NONE;
        top_ctrl  = '0;
        load_addr = 1'b0;
        mem_cmd   = MNONE;
        w         = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_reg)
            S_RST: begin
                top_ctrl[TOP_LOAD_PC]  = 1'b1;
                top_ctrl[TOP_RESET_PC] = 1'b1;
                w = 1'b1;
            end
            S_IF1: begin
                top_ctrl[TOP_ADDR_SEL] = 1'b1;
                mem_cmd = MREAD;
                w = 1'b1;
            end
            S_IF2: begin
                top_ctrl[TOP_ADDR_SEL] = 1'b1;
                top_ctrl[TOP_LOAD_IR]  = 1'b1;
                mem_cmd = MREAD;
                w = 1'b1;
            end
            S_UPD_PC: begin
                top_ctrl[TOP_LOAD_PC] = 1'b1;
                w = 1'b1;
            end
            S_GETA: begin
                dp_ctrl[DP_LOADA] = 1'b1;
                nsel = NSEL_RN;
            end
            S_GETB: begin
                dp_ctrl[DP_LOADB] = 1'b1;
                nsel = NSEL_RM;
            end
            S_EXEC:   dp_ctrl[DP_LOADC] = 1'b1;
            S_EXEC_A: begin
                dp_ctrl[DP_LOADC] = 1'b1;
                dp_ctrl[DP_ASEL]  = 1'b1;
            end
            S_CMP:    dp_ctrl[DP_LOADS] = 1'b1;
            S_ADDR: begin
                dp_ctrl[DP_LOADC] = 1'b1;
                dp_ctrl[DP_BSEL]  = 1'b1;
            end
            S_LDA:    load_addr = 1'b1;
            S_MEM_RD: mem_cmd = MREAD;
            S_GETD: begin
                dp_ctrl[DP_LOADB] = 1'b1;
                nsel = NSEL_RD;
            end
            S_PASSD: begin
                dp_ctrl[DP_LOADC] = 1'b1;
                dp_ctrl[DP_ASEL]  = 1'b1;
            end
            S_MEM_WR: mem_cmd = MWRITE;
            S_WR_REG: begin
                dp_ctrl[DP_VSEL_HI:DP_VSEL_LO] = VSEL_C;
                dp_ctrl[DP_WRITE] = 1'b1;
                nsel = NSEL_RD;
            end
            S_WR_IMM: begin
                dp_ctrl[DP_VSEL_HI:DP_VSEL_LO] = VSEL_IMM;
                dp_ctrl[DP_WRITE] = 1'b1;
                nsel = NSEL_RN;
            end
            S_WR_LDR: begin
                dp_ctrl[DP_VSEL_HI:DP_VSEL_LO] = VSEL_MDATA;
                dp_ctrl[DP_WRITE] = 1'b1;
                nsel = NSEL_RD;
                mem_cmd = MREAD;
            end
            S_ILL:    illegal = 1'b1;
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fsm_control_p.sv
// Self-checking bench for fsm_control_p: per-instruction micro-step tables
// checked cycle by cycle, directed cases plus random instruction streams.
module tb_fsm_control_p;

    localparam int unsigned LAT   = 3;
    localparam int unsigned CNT_W = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [8:0] dp_ctrl;
    logic [1:0] nsel;
    logic [3:0] top_ctrl;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       w;
    logic       halted;
    logic       illegal;
`ifdef FSM_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt;
`endif

    fsm_control_p #(.MEM_RD_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .dp_ctrl   (dp_ctrl),
        .nsel      (nsel),
        .top_ctrl  (top_ctrl),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd),
        .w         (w),
        .halted    (halted),
        .illegal   (illegal)
`ifdef FSM_INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [20:0] obs = {dp_ctrl, nsel, top_ctrl, load_addr, mem_cmd, w, halted, illegal};

    // dp_ctrl strobes {loada,loadb,loadc,loads,asel,bsel,vsel[1:0],write}
    localparam logic [8:0] D_LA = 9'h100, D_LB = 9'h080, D_LC = 9'h040, D_LS = 9'h020;
    localparam logic [8:0] D_AS = 9'h010, D_BS = 9'h008, D_WR = 9'h001;
    localparam logic [8:0] D_V10 = 9'h004, D_V11 = 9'h006;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [20:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [20:0] ev(input logic [8:0] dp, input logic [1:0] ns,
                                       input logic [3:0] tc, input logic la, input logic [1:0] mc,
                                       input logic wv, input logic hv, input logic il);
        return {dp, ns, tc, la, mc, wv, hv, il};
    endfunction

    function automatic logic [20:0] rst_vec();
        return ev(9'h0, 2'b11, 4'b1010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [20:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push(input string t, input logic [20:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    // Expected cycle-by-cycle outputs from IF1 to the last step of one instruction.
    task automatic build(input logic [2:0] oc, input logic [1:0] o);
        exp_q.delete();
        tag_q.delete();
        push("IF1", ev(9'h0, 2'b11, 4'b0001, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < int'(LAT); k++)
            push("IF2", ev(9'h0, 2'b11, 4'b0101, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
        push("UPD_PC", ev(9'h0, 2'b11, 4'b1000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
        push("DEC", ev(9'h0, 2'b11, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        if (oc == 3'b110 && o == 2'b10) begin
            push("WR_IMM", ev(D_V10 | D_WR, 2'b00, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        end else if ((oc == 3'b110 && o == 2'b00) || (oc == 3'b101 && o == 2'b11)) begin
            push("GETB", ev(D_LB, 2'b10, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            push("EXEC", ev(D_LC | D_AS, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            push("WR", ev(D_WR, 2'b01, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        end else if (oc == 3'b101) begin
            push("GETA", ev(D_LA, 2'b00, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            push("GETB", ev(D_LB, 2'b10, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            if (o == 2'b01) begin
                push("CMP", ev(D_LS, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            end else begin
                push("EXEC", ev(D_LC, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
                push("WR", ev(D_WR, 2'b01, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            end
        end else if (oc == 3'b011 || oc == 3'b100) begin
            push("GETA", ev(D_LA, 2'b00, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            push("ADDR", ev(D_LC | D_BS, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
            push("LDA", ev(9'h0, 2'b11, 4'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
            if (oc == 3'b011) begin
                for (int k = 0; k < int'(LAT); k++)
                    push("MEM_RD", ev(9'h0, 2'b11, 4'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
                push("WR_LDR", ev(D_V11 | D_WR, 2'b01, 4'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
            end else begin
                push("GETD", ev(D_LB, 2'b01, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
                push("PASSD", ev(D_LC | D_AS, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
                push("MEM_WR", ev(9'h0, 2'b11, 4'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0));
            end
        end else if (oc == 3'b111) begin
            push("HALTED", ev(9'h0, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
        end else begin
            push("ILL", ev(9'h0, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_cnt = '0;
        #1 chk("rst_async", rst_vec());
        @(negedge clk);
        chk("rst_hold", rst_vec());
        reset = 1'b1;
    endtask

    // Called just after a negedge; the DUT enters IF1 at the following posedge.
    task automatic run_instr(input logic [2:0] oc, input logic [1:0] o, input string stop_tag);
        opcode = oc;
        op = o;
        build(oc, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("op%b_%b_%s_%0d", oc, o, tag_q[i], i), exp_q[i]);
`ifdef FSM_INSTR_CNT_EN
            if (i == 0) begin
                n_checks++;
                assert (instr_cnt === model_cnt) else begin
                    n_fail++;
                    $error("FAIL instr_cnt observed=%0d expected=%0d", instr_cnt, model_cnt);
                end
            end
`endif
            if (tag_q[i] == stop_tag) begin
                do_reset();
                return;
            end
        end
        if (oc != 3'b111) model_cnt = model_cnt + 1'b1;
    endtask

    initial begin
        @(negedge clk);
        chk("reset_state", rst_vec());
        @(negedge clk);
        chk("reset_state2", rst_vec());
        reset = 1'b1;

        run_instr(3'b110, 2'b10, "");   // MOV imm
        run_instr(3'b011, 2'b00, "");   // LDR
        run_instr(3'b100, 2'b00, "");   // STR
        run_instr(3'b101, 2'b00, "");   // ADD
        run_instr(3'b101, 2'b01, "");   // CMP
        run_instr(3'b101, 2'b10, "");   // AND
        run_instr(3'b101, 2'b11, "");   // MVN
        run_instr(3'b110, 2'b00, "");   // MOV reg
        run_instr(3'b110, 2'b01, "");   // illegal
        run_instr(3'b000, 2'b00, "");   // illegal
        run_instr(3'b110, 2'b11, "");   // illegal

        run_instr(3'b101, 2'b00, "EXEC");
        run_instr(3'b011, 2'b00, "MEM_RD");
        run_instr(3'b011, 2'b01, "IF2");
        run_instr(3'b100, 2'b00, "");

        for (int n = 0; n < 40; n++)
            run_instr(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), "");

        for (int n = 0; n < 5; n++)
            run_instr(3'b101, 2'b01, "");

        run_instr(3'b111, 2'($urandom_range(0, 3)), "");
        for (int n = 0; n < 20; n++) begin
            opcode = 3'($urandom_range(0, 7));
            op = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("halt_hold", ev(9'h0, 2'b11, 4'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
        end
        do_reset();
        run_instr(3'b110, 2'b10, "");
        run_instr(3'b101, 2'b01, "");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
